idelay_tap_scan: RTL
====================

Name: idelay_tap_scan

Overview:
- Tap-sweep calibration controller that sits directly upstream of the IDELAYE3 wrapper and drives its 9-bit tap input, which is loaded every cycle.
- Steps the tap from 0 to TAP_MAX, waits for the delay to settle, then samples the delayed output (DATAOUT) and majority-votes it at each tap.
- Reports the first tap at which the voted level differs from the tap-0 level, i.e. the edge position of ref_signal relative to ref_clk_400m.
- Checks the tap readback from the delay element against the commanded tap.

Parameters:
- TAP_W, 9, tap value width (matches IDELAYE3 CNTVALUEIN/CNTVALUEOUT).
- TAP_MAX, 511, last tap scanned.
- SETTLE_CYC, 8, wait cycles after each tap change before sampling; must be >= 3.
- SAMPLE_CNT, 64, samples taken per tap.
- THRESH, 32, ones count at or above which the tap votes 1.

Ports:
- ref_clk_400m  in  1  the only clock; also clocks the delay element.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a scan; ignored unless the FSM is in IDLE.
- i_fine_signal  in  1  delayed signal from the wrapper's ref_signal_fine; asynchronous to the clock.
- i_cnt_readback  in  TAP_W  the wrapper's o_cnt_value.
- o_cnt_value  out  TAP_W  tap command to the wrapper's i_cnt_value.
- o_busy  out  1  high while a scan is in progress.
- o_done  out  1  one-cycle pulse at the end of a scan.
- o_found  out  1  an edge was found in the last scan.
- o_edge_tap  out  TAP_W  tap at which the edge was found; 0 if none.
- o_err  out  1  readback mismatch in the last scan.

Behaviour:
- Reset (asynchronous assert, any state): all outputs 0, FSM goes to IDLE, and the counters, sync flops and ref_bit clear.
- i_fine_signal passes through a 2-flop synchronizer before use. SETTLE_CYC >= 3 absorbs the synchronizer lag.
- FSM states: IDLE, SET, SETTLE, SAMPLE, EVAL, DONE.
- IDLE
  - o_busy = 0.
  - i_start = 1 → SET with tap = 0.
  - On that transition, clear o_found, o_edge_tap and o_err; set o_busy = 1 from the SET cycle onward.
- SET (1 cycle): drive o_cnt_value = tap; clear the wait and ones counters → SETTLE.
- SETTLE (SETTLE_CYC cycles)
  - On the last cycle, compare i_cnt_readback with tap.
  - Mismatch → o_err = 1 → DONE.
  - Match → SAMPLE.
- SAMPLE (SAMPLE_CNT cycles)
  - Add the synced bit to the ones counter each cycle.
  - The ones counter is clog2(SAMPLE_CNT+1) bits wide and cannot overflow.
- EVAL (1 cycle)
  - vote = (ones >= THRESH).
  - tap == 0: ref_bit = vote.
  - tap > 0 and vote != ref_bit: o_found = 1, o_edge_tap = tap → DONE.
  - Otherwise, tap == TAP_MAX → DONE with o_found = 0.
  - Otherwise, tap = tap + 1 → SET. The tap never wraps past TAP_MAX.
- DONE (1 cycle)
  - o_done = 1, o_busy = 0.
  - o_cnt_value = o_edge_tap if found, else 0 (also 0 on error).
  - → IDLE.
- Per-tap time = 2 + SETTLE_CYC + SAMPLE_CNT, which is 74 cycles with defaults.
  - o_done rises N*74 cycles after the first o_busy cycle, where N = taps evaluated.
  - On an error, the aborting tap counts as 1 + SETTLE_CYC cycles.
- Result hold: o_found, o_edge_tap, o_err and o_cnt_value hold until the next accepted i_start or reset.
- i_start while busy is ignored: no restart, no queuing.
- i_start coincident with DONE is ignored, because the FSM is not yet in IDLE.
- Reset mid-scan: immediate abort with outputs 0 and no o_done pulse.
- The tap-0 vote never produces a found, because an edge requires a level change.

Test Plan:
- i_fine_signal = 0 constant, readback = o_cnt_value, i_start pulse → 512 taps scanned; o_done at 512*74 = 37888 cycles after busy; o_found = 0, o_edge_tap = 0, o_cnt_value = 0, o_err = 0.
- Model: delayed signal = 1 for tap < 100, 0 for tap >= 100 → o_found = 1, o_edge_tap = 100, o_cnt_value = 100; o_done at 101*74 = 7474 cycles.
- i_cnt_readback stuck at 0 → tap 0 passes, tap 1 mismatch; o_err = 1, o_found = 0, o_cnt_value = 0; o_done at 74 + 9 = 83 cycles.
- Per-tap ones count of exactly THRESH = 32 → vote 1; count 31 → vote 0. Place a 32→31 transition at tap 5 → o_edge_tap = 5.
- Assert reset at tap 40 → all outputs 0 immediately and no o_done; a subsequent i_start scans again from tap 0.
- i_start pulsed again at tap 10 of a scan → ignored; the scan completes with the original timing and result.

Source files
------------

// File: rtl/idelay_tap_scan.sv
// Tap-sweep calibration controller for an IDELAYE3 wrapper: steps the tap, settles,
// majority-votes the delayed signal and reports the first tap whose level differs from tap 0.
module idelay_tap_scan #(
  parameter int TAP_W      = 9,
  parameter int TAP_MAX    = 511,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CNT = 64,
  parameter int THRESH     = 32
) (
  input  logic             ref_clk_400m,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_fine_signal,
  input  logic [TAP_W-1:0] i_cnt_readback,
  output logic [TAP_W-1:0] o_cnt_value,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_found,
  output logic [TAP_W-1:0] o_edge_tap,
  output logic             o_err
);

  localparam int ONES_W  = $clog2(SAMPLE_CNT + 1);
  localparam int CYC_MAX = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_SETTLE, S_SAMPLE, S_EVAL, S_DONE
  } state_t;

  state_t            state, state_next;
  logic [TAP_W-1:0]  tap;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [ONES_W-1:0] ones;
  logic              sync1, sync2;
  logic              ref_bit;

  logic vote, accept, abort, hit, miss, step, settle_last, sample_last;

  assign settle_last = (cyc_cnt == CYC_W'(SETTLE_CYC - 1));
  assign sample_last = (cyc_cnt == CYC_W'(SAMPLE_CNT - 1));
  assign vote        = (ones >= ONES_W'(THRESH));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    abort      = 1'b0;
    hit        = 1'b0;
    miss       = 1'b0;
    step       = 1'b0;
    unique case (state)
      S_IDLE: if (i_start) begin
        accept     = 1'b1;
        state_next = S_SET;
      end
      S_SET: state_next = S_SETTLE;
      S_SETTLE: if (settle_last) begin
        if (i_cnt_readback != tap) begin
          abort      = 1'b1;
          state_next = S_DONE;
        end else begin
          state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: if (sample_last) state_next = S_EVAL;
      S_EVAL: begin
        // Tap 0 only establishes the reference level; an edge needs a later tap to differ.
        if ((tap != '0) && (vote != ref_bit)) begin
          hit        = 1'b1;
          state_next = S_DONE;
        end else if (tap == TAP_W'(TAP_MAX)) begin
          miss       = 1'b1;
          state_next = S_DONE;
        end else begin
          step       = 1'b1;
          state_next = S_SET;
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE) && (state != S_DONE);
  assign o_done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ref_clk_400m or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      tap         <= '0;
      cyc_cnt     <= '0;
      ones        <= '0;
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      ref_bit     <= 1'b0;
      o_cnt_value <= '0;
      o_found     <= 1'b0;
      o_edge_tap  <= '0;
      o_err       <= 1'b0;
    end else begin
      state <= state_next;
      sync1 <= i_fine_signal;
      sync2 <= sync1;

      if (accept) begin
        tap         <= '0;
        o_cnt_value <= '0;
        o_found     <= 1'b0;
        o_edge_tap  <= '0;
        o_err       <= 1'b0;
      end

      unique case (state)
        S_SET: begin
          cyc_cnt <= '0;
          ones    <= '0;
        end
        S_SETTLE: cyc_cnt <= settle_last ? '0 : cyc_cnt + 1'b1;
        S_SAMPLE: begin
          cyc_cnt <= cyc_cnt + 1'b1;
          ones    <= ones + ONES_W'(sync2);
        end
        default: ;
      endcase

      if (abort) begin
        o_err       <= 1'b1;
        o_cnt_value <= '0;
      end

      if (state == S_EVAL && tap == '0) ref_bit <= vote;

      if (hit) begin
        o_found     <= 1'b1;
        o_edge_tap  <= tap;
        o_cnt_value <= tap;
      end
      if (miss) o_cnt_value <= '0;
      if (step) begin
        tap         <= tap + 1'b1;
        o_cnt_value <= tap + 1'b1;
      end
    end
  end

endmodule
